sparse_zeroskip_index_stream: RTL and testbench
===============================================

Name: sparse_zeroskip_index_stream

Overview:
- Streaming, parametrised successor to the combinational bit-mask nonzero index finder.
- Accepts one GROUP-bit compression map (cmap) per valid/ready handshake. Emits the positions of its set bits, lowest first, as beats of up to LANES indices.
- A group may hold any nonzero count from 0 to GROUP; it is not fixed at a compile-time nonzero count.
- The whole index sequence is replayed REPEAT times, once per data group sharing the cmap. Sits between cmap fetch and the zero-skip operand gather.

Parameters:
- GROUP, 16, cmap width (bits per sparse group); at least 2.
- LANES, 8, max indices emitted per output beat; 1 ≤ LANES ≤ GROUP.
- REPEAT, 8, data groups sharing one cmap; index sequence replayed REPEAT times; at least 1.
- IDX_W, $clog2(GROUP), index width; derived, not overridden.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  cmap valid.
- in_ready  out  1  block can accept cmap this cycle.
- in_cmap  in  GROUP  bit mask; bit k set means element k nonzero.
- out_valid  out  1  beat valid.
- out_ready  in  1  downstream accepts beat.
- out_index  out  LANES*IDX_W  packed indices, lane 0 in LSBs.
- out_lane_vld  out  LANES  per-lane valid, always a contiguous run from lane 0.
- out_last  out  1  final beat of current replay.
- out_last_rep  out  1  final beat of final replay (implies out_last).
- out_rep  out  $clog2(REPEAT+1)  current replay number, 0-based.
- out_nz_cnt  out  $clog2(GROUP+1)  popcount of current cmap.

Behaviour:
- Reset (async, active-high):
  - state=IDLE; in_ready=1; out_valid=0.
  - out_index, out_lane_vld, out_last, out_last_rep, out_rep, out_nz_cnt all 0.
  - Internal cmap and residual registers cleared.
- States:
  - IDLE: no group held. in_ready=1.
  - EMIT: out_valid=1, beat registered.
- Accept: in_valid & in_ready. In the same cycle:
  - Store cmap; set residual = cmap, rep = 0; register popcount.
  - Compute and register the first beat.
  - out_valid asserts the next cycle, so latency is 1 cycle.
- Beat formation (combinational from residual):
  - Take the lowest min(LANES, popcount(residual)) set bits, in ascending order, into lanes 0..n-1.
  - Set out_lane_vld = (1<<n)-1. Unused lanes carry index 0.
  - next_residual = residual with those bits cleared.
  - out_last = (next_residual == 0).
- Zero cmap: exactly one beat per replay, with out_lane_vld=0, out_last=1, out_nz_cnt=0. Never skipped, so downstream stays group-aligned.
- Beats per replay = max(1, ceil(popcount/LANES)).
- Advance on out_valid & out_ready:
  - If not out_last: residual = next_residual; register next beat.
  - If out_last and rep < REPEAT-1: rep+1; residual reloaded from stored cmap; first beat recomputed.
  - If out_last_rep: group done.
- Back-to-back groups:
  - in_ready = IDLE | (out_valid & out_ready & out_last_rep). This is a combinational path from out_ready; permitted.
  - If a new cmap is accepted in the done cycle, EMIT continues with no bubble. Otherwise go to IDLE.
- Backpressure: while out_valid & !out_ready, all out_* hold stable and no state changes.
- in_cmap is ignored when in_ready=0.
- Reset asserted mid-EMIT: the group is discarded immediately; outputs return to reset values within the same cycle (async).
- Throughput: one beat per cycle when out_ready is held high.

Decomposition:
- Shared package sparse_zeroskip_pkg:
  - function idx_w(group);
  - function popcount;
  - typedef for the beat struct (index array, lane_vld, last, last_rep).
- One sub-module: sparse_zeroskip_lane_extract.
  - Purely combinational; parameters GROUP, LANES.
  - Inputs: residual. Outputs: indices, lane_vld, next_residual.
  - Built as a LANES-deep lowest-set-bit chain, each stage masking bits found by earlier stages.
- The top module holds the FSM, registers, and replay counter.

Test Plan:
- GROUP=16, LANES=8, REPEAT=2; cmap 0x00FF, out_ready=1 -> two beats: indices 0..7, lane_vld 0xFF, out_last=1 each; rep 0 then 1; last_rep on the 2nd; nz_cnt 8; in_ready high in the 2nd beat cycle.
- Same config; cmap 0xFFFF -> per replay, beat A = 0..7 (last=0), beat B = 8..15 (last=1); 4 beats total; nz_cnt 16.
- Same config; cmap 0x8001 then 0x0000 back-to-back -> 0x8001 gives indices {0,15}, lane_vld 0x03 on each replay. Then 0x0000 follows with no idle cycle: lane_vld 0, last=1, two beats.
- GROUP=8, LANES=3, REPEAT=1; cmap 0xB5 -> beat {0,2,4} lane_vld 0b111 last=0, then {5,7,0} lane_vld 0b011 last=1 last_rep=1.
- Backpressure: hold out_ready=0 for 5 cycles mid-group (cmap 0xFFFF) -> outputs constant, in_ready=0, no beat lost or duplicated once released.
- Assert rst during the 2nd beat of cmap 0xFFFF -> out_valid=0 immediately, in_ready=1 after release. Next cmap 0x0003 yields {0,1}, rep 0.

Source files
------------

// File: rtl/sparse_zeroskip_pkg.sv
// rtl/sparse_zeroskip_pkg.sv - shared types and helpers for the zero-skip index streamer
package sparse_zeroskip_pkg;

    localparam int MAX_W         = 256;
    localparam int MAX_LANES     = 16;
    localparam int MAX_IDX_W     = 8;

    typedef enum logic {
        ST_IDLE,
        ST_EMIT
    } state_t;

    typedef struct packed {
        logic [MAX_LANES*MAX_IDX_W-1:0] index;
        logic [MAX_LANES-1:0]           lane_vld;
        logic                           last;
        logic                           last_rep;
    } beat_t;

    function automatic int idx_w(input int group);
        return (group < 2) ? 1 : $clog2(group);
    endfunction

    function automatic logic [8:0] popcount(input logic [MAX_W-1:0] v);
        logic [8:0] cnt;
        cnt = '0;
        for (int i = 0; i < MAX_W; i++) begin
            cnt = cnt + 9'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/sparse_zeroskip_lane_extract.sv
// rtl/sparse_zeroskip_lane_extract.sv - combinational lowest-set-bit chain forming one beat
module sparse_zeroskip_lane_extract
    import sparse_zeroskip_pkg::*;
#(
    parameter int GROUP = 16,
    parameter int LANES = 8
) (
    input  logic [GROUP-1:0]                residual,
    output logic [LANES*idx_w(GROUP)-1:0]   indices,
    output logic [LANES-1:0]                lane_vld,
    output logic [GROUP-1:0]                next_residual
);

    localparam int IDX_W = idx_w(GROUP);

    logic [GROUP-1:0] rem;
    logic [GROUP-1:0] low;

    // Each stage isolates the lowest remaining bit and removes it for the next stage.
    always_comb begin
        rem      = residual;
        low      = '0;
        indices  = '0;
        lane_vld = '0;
        for (int l = 0; l < LANES; l++) begin
            low         = rem & (~rem + GROUP'(1));
            lane_vld[l] = |rem;
            for (int b = 0; b < GROUP; b++) begin
                if (low[b]) begin
                    indices[l*IDX_W +: IDX_W] = IDX_W'(b);
                end
            end
            rem = rem & ~low;
        end
        next_residual = rem;
    end

endmodule

// File: rtl/sparse_zeroskip_index_stream.sv
// rtl/sparse_zeroskip_index_stream.sv - streams nonzero indices of a cmap, replayed per data group
module sparse_zeroskip_index_stream
    import sparse_zeroskip_pkg::*;
#(
    parameter int GROUP  = 16,
    parameter int LANES  = 8,
    parameter int REPEAT = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [GROUP-1:0]                in_cmap,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [LANES*idx_w(GROUP)-1:0]   out_index,
    output logic [LANES-1:0]                out_lane_vld,
    output logic                            out_last,
    output logic                            out_last_rep,
    output logic [$clog2(REPEAT+1)-1:0]     out_rep,
    output logic [$clog2(GROUP+1)-1:0]      out_nz_cnt
);

    localparam int IDX_W = idx_w(GROUP);
    localparam int REP_W = $clog2(REPEAT+1);
    localparam int CNT_W = $clog2(GROUP+1);
    localparam logic [REP_W-1:0] FINAL_REP = REP_W'(REPEAT-1);

    state_t                 state;
    logic [GROUP-1:0]       cmap_q;
    logic [GROUP-1:0]       residual_q;
    logic [GROUP-1:0]       ext_in;
    logic [GROUP-1:0]       ext_next;
    logic [LANES*IDX_W-1:0] ext_idx;
    logic [LANES-1:0]       ext_vld;
    logic                   ext_last;
    logic [REP_W-1:0]       beat_rep;
    logic                   fire;
    logic                   accept;
    logic                   load;

    assign fire     = out_valid & out_ready;
    assign in_ready = (state == ST_IDLE) | (fire & out_last_rep);
    assign accept   = in_valid & in_ready;
    assign load     = accept | (fire & ~out_last_rep);

    // Source of the next beat: a fresh cmap, a replay reload, or the leftover residual.
    always_comb begin
        ext_in   = residual_q;
        beat_rep = out_rep;
        if (accept) begin
            ext_in   = in_cmap;
            beat_rep = '0;
        end else if (out_last) begin
            ext_in   = cmap_q;
            beat_rep = out_rep + REP_W'(1);
        end
    end

    sparse_zeroskip_lane_extract #(
        .GROUP(GROUP),
        .LANES(LANES)
    ) u_extract (
        .residual     (ext_in),
        .indices      (ext_idx),
        .lane_vld     (ext_vld),
        .next_residual(ext_next)
    );

    assign ext_last = (ext_next == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            out_valid    <= 1'b0;
            cmap_q       <= '0;
            residual_q   <= '0;
            out_index    <= '0;
            out_lane_vld <= '0;
            out_last     <= 1'b0;
            out_last_rep <= 1'b0;
            out_rep      <= '0;
            out_nz_cnt   <= '0;
        end else begin
            if (load) begin
                out_index    <= ext_idx;
                out_lane_vld <= ext_vld;
                out_last     <= ext_last;
                out_last_rep <= ext_last & (beat_rep == FINAL_REP);
                out_rep      <= beat_rep;
                residual_q   <= ext_next;
            end
            if (accept) begin
                state      <= ST_EMIT;
                out_valid  <= 1'b1;
                cmap_q     <= in_cmap;
                out_nz_cnt <= CNT_W'(popcount(MAX_W'(in_cmap)));
            end else if (fire & out_last_rep) begin
                state     <= ST_IDLE;
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sparse_zeroskip_index_stream.sv
// tb/tb_sparse_zeroskip_index_stream.sv - self-checking bench for the zero-skip index streamer
module tb_sparse_zeroskip_index_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // Instance A: GROUP=16, LANES=8, REPEAT=2
    logic        a_in_valid = 1'b0;
    logic        a_in_ready;
    logic [15:0] a_in_cmap = '0;
    logic        a_out_valid;
    logic        a_out_ready = 1'b1;
    logic [31:0] a_out_index;
    logic [7:0]  a_out_lane_vld;
    logic        a_out_last;
    logic        a_out_last_rep;
    logic [1:0]  a_out_rep;
    logic [4:0]  a_out_nz_cnt;

    // Instance B: GROUP=8, LANES=3, REPEAT=1
    logic        b_in_valid = 1'b0;
    logic        b_in_ready;
    logic [7:0]  b_in_cmap = '0;
    logic        b_out_valid;
    logic        b_out_ready = 1'b1;
    logic [8:0]  b_out_index;
    logic [2:0]  b_out_lane_vld;
    logic        b_out_last;
    logic        b_out_last_rep;
    logic [0:0]  b_out_rep;
    logic [3:0]  b_out_nz_cnt;

    int checks = 0;
    int passes = 0;

    typedef struct {
        int idx[8];
        int vld;
        bit last;
        bit last_rep;
        int rep;
        int nz;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea;
    exp_t eb;

    always #5 clk = ~clk;

    sparse_zeroskip_index_stream #(.GROUP(16), .LANES(8), .REPEAT(2)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_cmap(a_in_cmap),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_index(a_out_index),
        .out_lane_vld(a_out_lane_vld), .out_last(a_out_last), .out_last_rep(a_out_last_rep),
        .out_rep(a_out_rep), .out_nz_cnt(a_out_nz_cnt)
    );

    sparse_zeroskip_index_stream #(.GROUP(8), .LANES(3), .REPEAT(1)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_cmap(b_in_cmap),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_index(b_out_index),
        .out_lane_vld(b_out_lane_vld), .out_last(b_out_last), .out_last_rep(b_out_last_rep),
        .out_rep(b_out_rep), .out_nz_cnt(b_out_nz_cnt)
    );

    function automatic void chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endfunction

    // Expected beats from the set-bit list: chunk by LANES, one empty beat for a zero map.
    function automatic void model_push(input int id, input int cmap, input int group,
                                       input int lanes, input int reps);
        int pos[$];
        int n;
        int beats;
        exp_t e;
        for (int k = 0; k < group; k++) if (((cmap >> k) & 1) == 1) pos.push_back(k);
        n = pos.size();
        beats = (n == 0) ? 1 : (n + lanes - 1) / lanes;
        for (int r = 0; r < reps; r++) begin
            for (int b = 0; b < beats; b++) begin
                for (int l = 0; l < 8; l++) e.idx[l] = 0;
                e.vld = 0;
                for (int l = 0; l < lanes; l++) begin
                    if (b * lanes + l < n) begin
                        e.idx[l] = pos[b * lanes + l];
                        e.vld = e.vld | (1 << l);
                    end
                end
                e.last     = (b == beats - 1);
                e.last_rep = e.last && (r == reps - 1);
                e.rep      = r;
                e.nz       = n;
                if (id == 0) qa.push_back(e);
                else qb.push_back(e);
            end
        end
    endfunction

    function automatic longint pack(input exp_t e, input int w);
        longint p = 0;
        for (int l = 0; l < 8; l++) p = p | (longint'(e.idx[l]) << (l * w));
        return p;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            chk("a_rst_out_valid", a_out_valid, 0);
            qa.delete();
        end else begin
            if (qa.size() == 0) chk("a_in_ready", a_in_ready, 1);
            else chk("a_in_ready", a_in_ready, a_out_ready && qa[0].last_rep);
            chk("a_out_valid", a_out_valid, qa.size() != 0);
            if (a_out_valid && qa.size() != 0) begin
                ea = qa[0];
                chk("a_index", a_out_index, pack(ea, 4));
                chk("a_lane_vld", a_out_lane_vld, ea.vld);
                chk("a_last", a_out_last, ea.last);
                chk("a_last_rep", a_out_last_rep, ea.last_rep);
                chk("a_rep", a_out_rep, ea.rep);
                chk("a_nz_cnt", a_out_nz_cnt, ea.nz);
                if (a_out_ready) void'(qa.pop_front());
            end
            if (a_in_valid && a_in_ready) model_push(0, int'(a_in_cmap), 16, 8, 2);
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("b_rst_out_valid", b_out_valid, 0);
            qb.delete();
        end else begin
            if (qb.size() == 0) chk("b_in_ready", b_in_ready, 1);
            else chk("b_in_ready", b_in_ready, b_out_ready && qb[0].last_rep);
            chk("b_out_valid", b_out_valid, qb.size() != 0);
            if (b_out_valid && qb.size() != 0) begin
                eb = qb[0];
                chk("b_index", b_out_index, pack(eb, 3));
                chk("b_lane_vld", b_out_lane_vld, eb.vld);
                chk("b_last", b_out_last, eb.last);
                chk("b_last_rep", b_out_last_rep, eb.last_rep);
                chk("b_rep", b_out_rep, eb.rep);
                chk("b_nz_cnt", b_out_nz_cnt, eb.nz);
                if (b_out_ready) void'(qb.pop_front());
            end
            if (b_in_valid && b_in_ready) model_push(1, int'(b_in_cmap), 8, 3, 1);
        end
    end

    task automatic a_offer(input int c);
        a_in_cmap  = 16'(c);
        a_in_valid = 1'b1;
    endtask

    task automatic b_offer(input int c);
        b_in_cmap  = 8'(c);
        b_in_valid = 1'b1;
    endtask

    task automatic a_wait_accept();
        bit done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (a_in_ready) begin
                @(posedge clk);
                #1;
                a_in_valid = 1'b0;
                done = 1;
            end
        end
        if (!done) begin
            chk("a_accept_timeout", 0, 1);
            a_in_valid = 1'b0;
        end
    endtask

    task automatic b_wait_accept();
        bit done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (b_in_ready) begin
                @(posedge clk);
                #1;
                b_in_valid = 1'b0;
                done = 1;
            end
        end
        if (!done) begin
            chk("b_accept_timeout", 0, 1);
            b_in_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (qa.size() == 0 && qb.size() == 0 && !a_out_valid && !b_out_valid) done = 1;
        end
        if (!done) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_a_in_ready", a_in_ready, 1);
        chk("rst_a_index", a_out_index, 0);
        chk("rst_a_lane_vld", a_out_lane_vld, 0);
        chk("rst_a_last", {a_out_last, a_out_last_rep}, 0);
        chk("rst_a_rep_nz", {a_out_rep, a_out_nz_cnt}, 0);
        chk("rst_b_in_ready", b_in_ready, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 0x00FF: one full beat per replay
        a_offer(16'h00FF);
        a_wait_accept();
        @(negedge clk);
        chk("t1_index", a_out_index, 32'h76543210);
        chk("t1_lane_vld", a_out_lane_vld, 8'hFF);
        chk("t1_rep0", a_out_rep, 0);
        chk("t1_nz", a_out_nz_cnt, 8);
        @(negedge clk);
        chk("t1_rep1", a_out_rep, 1);
        chk("t1_last_rep", a_out_last_rep, 1);
        chk("t1_in_ready", a_in_ready, 1);
        wait_idle();

        // 0xFFFF: two beats per replay
        a_offer(16'hFFFF);
        a_wait_accept();
        @(negedge clk);
        chk("t2_beat_a", a_out_index, 32'h76543210);
        chk("t2_last_a", a_out_last, 0);
        chk("t2_nz", a_out_nz_cnt, 16);
        @(negedge clk);
        chk("t2_beat_b", a_out_index, 32'hFEDCBA98);
        chk("t2_last_b", a_out_last, 1);
        wait_idle();

        // 0x8001 then 0x0000 back-to-back
        a_offer(16'h8001);
        a_wait_accept();
        a_offer(16'h0000);
        @(negedge clk);
        chk("t3_index", a_out_index, 32'h000000F0);
        chk("t3_lane_vld", a_out_lane_vld, 8'h03);
        a_wait_accept();
        @(negedge clk);
        chk("t3_zero_valid", a_out_valid, 1);
        chk("t3_zero_vld", a_out_lane_vld, 0);
        chk("t3_zero_last", a_out_last, 1);
        chk("t3_zero_nz", a_out_nz_cnt, 0);
        wait_idle();

        // Backpressure on the second beat of 0xFFFF
        a_offer(16'hFFFF);
        a_wait_accept();
        @(posedge clk);
        #1;
        a_out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t5_hold_index", a_out_index, 32'hFEDCBA98);
            chk("t5_hold_in_ready", a_in_ready, 0);
            chk("t5_hold_rep", a_out_rep, 0);
        end
        a_out_ready = 1'b1;
        wait_idle();

        // Reset during the second beat of 0xFFFF
        a_offer(16'hFFFF);
        a_wait_accept();
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_rst_valid_async", a_out_valid, 0);
        @(negedge clk);
        chk("t6_rst_in_ready", a_in_ready, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        a_offer(16'h0003);
        a_wait_accept();
        @(negedge clk);
        chk("t6_index", a_out_index, 32'h00000010);
        chk("t6_lane_vld", a_out_lane_vld, 8'h03);
        chk("t6_rep", a_out_rep, 0);
        wait_idle();

        // GROUP=8, LANES=3, REPEAT=1 with 0xB5
        b_offer(8'hB5);
        b_wait_accept();
        @(negedge clk);
        chk("t4_index0", b_out_index, 9'h110);
        chk("t4_vld0", b_out_lane_vld, 3'b111);
        chk("t4_last0", b_out_last, 0);
        @(negedge clk);
        chk("t4_index1", b_out_index, 9'h03D);
        chk("t4_vld1", b_out_lane_vld, 3'b011);
        chk("t4_last1", {b_out_last, b_out_last_rep}, 2'b11);
        wait_idle();

        begin
            int tbl[6] = '{8'h00, 8'hFF, 8'h01, 8'h80, 8'h49, 8'h7E};
            foreach (tbl[i]) begin
                b_offer(tbl[i]);
                b_wait_accept();
            end
        end
        wait_idle();

        chk("end_qa_empty", qa.size(), 0);
        chk("end_qb_empty", qb.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got %0d/%0d", passes, checks);
        $fatal(1);
    end

endmodule
